ms_uart_rx: RTL and testbench

Receive engine of the ms_uart core. It sits between the RX pin and the RX FIFO, directly upstream of the FIFO write port that ultimately feeds the Wishbone DATA register. It oversamples the line 16x using the software-programmed prescale, majority-votes each bit, and frames 8N1 characters. Each good character is pushed into the RX FIFO; framing errors and overruns are flagged as one-cycle pulses.

---
 rtl/ms_uart_pkg.sv | 22 ++
 rtl/ms_uart_baud_tick.sv | 27 ++
 rtl/ms_uart_rx.sv | 144 ++++++++++++++
 tb/tb_ms_uart_rx.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/ms_uart_pkg.sv
// Shared types and constants for the ms_uart core.
// maj3 is the 2-of-3 vote used to recover each oversampled bit.
package ms_uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  localparam int OVERSAMPLE = 16;
  localparam int SAMPLE_LO  = 7;
  localparam int SAMPLE_MID = 8;
  localparam int SAMPLE_HI  = 9;
  localparam int DATA_BITS  = 8;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/ms_uart_baud_tick.sv
// Prescale counter: one-clock tick every prescale+1 clocks.
// Shared by the RX and TX engines of ms_uart.
module ms_uart_baud_tick #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr,
  input  logic [W-1:0] prescale,
  output logic         tick
);

  logic [W-1:0] cnt;
  logic         hit;

  // >= keeps a lowered prescale from running the counter through a full wrap
  assign hit  = (cnt >= prescale);
  assign tick = hit & ~clr;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)    cnt <= '0;
    else if (clr) cnt <= '0;
    else if (hit) cnt <= '0;
    else          cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/ms_uart_rx.sv
// ms_uart receive engine: 16x oversampled, majority-voted 8N1 framing
// feeding the RX FIFO write port.
module ms_uart_rx
  import ms_uart_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en,
  input  logic [15:0] prescale,
  input  logic        RX,
  input  logic        fifo_full,
  output logic        wr,
  output logic [7:0]  wdata,
  output logic        frame_err,
  output logic        overrun,
  output logic        busy
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s, rx_q;

  rx_state_t state, state_n;
  logic       tick, start_det, clr_tick;
  logic [3:0] s_cnt;
  logic [2:0] smp;
  logic [2:0] bit_idx;
  logic [7:0] shreg;
  logic       vote, at_bit_end, at_stop_pt;
  logic       shift, push, fe, ov;

  // synchronizer idles high so reset never looks like a start edge
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '1;
      rx_q   <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], RX};
      rx_q   <= rx_s;
    end
  end

  assign rx_s = sync_q[SYNC_STAGES-1];

  assign start_det = (state == IDLE) & en & ~rx_s & rx_q;
  assign clr_tick  = ~en | start_det;

  ms_uart_baud_tick #(.W(16)) u_tick (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr      (clr_tick),
    .prescale (prescale),
    .tick     (tick)
  );

  assign at_bit_end = tick & (s_cnt == 4'(OVERSAMPLE - 1));
  assign at_stop_pt = tick & (s_cnt == 4'(SAMPLE_HI));

  // stop bit decides on its third sample, so use the live line for it
  assign vote = (state == STOP) ? maj3(smp[0], smp[1], rx_s)
                                : maj3(smp[0], smp[1], smp[2]);

  always_comb begin
    state_n = state;
    shift   = 1'b0;
    push    = 1'b0;
    fe      = 1'b0;
    ov      = 1'b0;
    if (!en) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE:  if (start_det) state_n = START;
        START: if (at_bit_end) state_n = vote ? IDLE : DATA;
        DATA: begin
          if (at_bit_end) begin
            shift = 1'b1;
            if (bit_idx == 3'(DATA_BITS - 1)) state_n = STOP;
          end
        end
        STOP: begin
          if (at_stop_pt) begin
            state_n = IDLE;
            if (!vote)          fe   = 1'b1;
            else if (fifo_full) ov   = 1'b1;
            else                push = 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s_cnt     <= '0;
      smp       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      wr        <= 1'b0;
      wdata     <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else if (!en) begin
      s_cnt     <= '0;
      smp       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      wr        <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      wr        <= push;
      frame_err <= fe;
      overrun   <= ov;
      if (push) wdata <= shreg;

      if (start_det)  s_cnt <= '0;
      else if (tick)  s_cnt <= s_cnt + 1'b1;

      if (tick) begin
        if (s_cnt == 4'(SAMPLE_LO))  smp[0] <= rx_s;
        if (s_cnt == 4'(SAMPLE_MID)) smp[1] <= rx_s;
        if (s_cnt == 4'(SAMPLE_HI))  smp[2] <= rx_s;
      end

      if (start_det) begin
        bit_idx <= '0;
      end else if (shift) begin
        shreg   <= {vote, shreg[7:1]};
        bit_idx <= bit_idx + 1'b1;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_ms_uart_rx.sv
// Directed bench for ms_uart_rx: frames driven bit-by-bit, pulses logged
// with their cycle numbers and compared against hand-derived timing.
module tb_ms_uart_rx;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        en = 1'b0;
  logic [15:0] prescale = 16'd0;
  logic        rx_line = 1'b1;
  logic        fifo_full = 1'b0;
  logic        wr, frame_err, overrun, busy;
  logic [7:0]  wdata;

  int vec = 0;
  int miss = 0;
  int cyc = 0;

  int       wr_cnt = 0, fe_cnt = 0, ov_cnt = 0;
  int       wr_cyc = 0, prev_wr_cyc = 0, fe_cyc = 0, ov_cyc = 0;
  logic [7:0] wr_data = 8'h00, prev_data = 8'h00;

  ms_uart_rx #(.SYNC_STAGES(2)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .en        (en),
    .prescale  (prescale),
    .RX        (rx_line),
    .fifo_full (fifo_full),
    .wr        (wr),
    .wdata     (wdata),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  always @(negedge clk_i) begin
    if (wr) begin
      wr_cnt      <= wr_cnt + 1;
      prev_wr_cyc <= wr_cyc;
      wr_cyc      <= cyc;
      prev_data   <= wr_data;
      wr_data     <= wdata;
    end
    if (frame_err) begin
      fe_cnt <= fe_cnt + 1;
      fe_cyc <= cyc;
    end
    if (overrun) begin
      ov_cnt <= ov_cnt + 1;
      ov_cyc <= cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  // entered 1 time unit after a clock edge; start bit lands at cycle n0
  task automatic send(input logic [7:0] b, input logic stop, input int p, output int n0);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    n0 = cyc;
    for (int i = 0; i < 10; i++) begin
      rx_line = fr[i];
      repeat (16 * (p + 1)) @(posedge clk_i);
      #1;
    end
  endtask

  initial begin
    int n0, n1;

    #12;
    chk("rst_wr", wr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_fe", frame_err, 0);
    chk("rst_ov", overrun, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    en    = 1'b1;
    clks(20);

    // 0xA5 at 16 clocks per bit; push visible 157 edges after start edge drive
    prescale = 16'd0;
    send(8'hA5, 1'b1, 0, n0);
    rx_line = 1'b1;
    clks(10);
    chk("a5_wr_cnt", wr_cnt, 1);
    chk("a5_wr_cyc", wr_cyc, n0 + 157);
    chk("a5_wdata", wr_data, 8'hA5);
    chk("a5_fe_cnt", fe_cnt, 0);
    chk("a5_ov_cnt", ov_cnt, 0);
    chk("a5_busy", busy, 0);

    // back-to-back 0x00, 0xFF at prescale 3
    prescale = 16'd3;
    clks(20);
    send(8'h00, 1'b1, 3, n0);
    send(8'hFF, 1'b1, 3, n1);
    rx_line = 1'b1;
    clks(80);
    chk("b2b_wr_cnt", wr_cnt, 3);
    chk("b2b_first", prev_data, 8'h00);
    chk("b2b_second", wr_data, 8'hFF);
    chk("b2b_cyc", wr_cyc, n0 + 640 + 3 + 154 * 4);
    chk("b2b_gap", wr_cyc - prev_wr_cyc, 640);

    // 4-clock glitch: false start, back to idle after the start-bit vote
    prescale = 16'd0;
    clks(20);
    n0 = cyc;
    rx_line = 1'b0;
    clks(4);
    rx_line = 1'b1;
    clks(6);
    chk("glitch_busy_mid", busy, 1);
    clks(8);
    chk("glitch_busy_18", busy, 1);
    clks(1);
    chk("glitch_busy_19", busy, 0);
    clks(20);
    chk("glitch_wr_cnt", wr_cnt, 3);
    chk("glitch_fe_cnt", fe_cnt, 0);

    // 0x3C with stop bit 0, then line held low as a break
    send(8'h3C, 1'b0, 0, n0);
    clks(400);
    chk("fe_cnt", fe_cnt, 1);
    chk("fe_cyc", fe_cyc, n0 + 157);
    chk("fe_wr_cnt", wr_cnt, 3);
    chk("fe_ov_cnt", ov_cnt, 0);
    chk("brk_busy", busy, 0);
    rx_line = 1'b1;
    clks(30);
    chk("brk_fe_cnt", fe_cnt, 1);
    chk("brk_busy_hi", busy, 0);

    // overrun while FIFO full
    fifo_full = 1'b1;
    send(8'h55, 1'b1, 0, n0);
    rx_line = 1'b1;
    clks(10);
    fifo_full = 1'b0;
    chk("ov_cnt", ov_cnt, 1);
    chk("ov_cyc", ov_cyc, n0 + 157);
    chk("ov_wr_cnt", wr_cnt, 3);
    chk("ov_wdata", wdata, 8'hFF);

    // enable dropped mid DATA, then a clean 0x81
    rx_line = 1'b0;
    clks(60);
    chk("abort_busy_pre", busy, 1);
    en = 1'b0;
    clks(1);
    chk("abort_busy", busy, 0);
    rx_line = 1'b1;
    clks(40);
    en = 1'b1;
    clks(20);
    chk("abort_wr_cnt", wr_cnt, 3);
    chk("abort_fe_cnt", fe_cnt, 1);
    chk("abort_ov_cnt", ov_cnt, 1);
    send(8'h81, 1'b1, 0, n0);
    rx_line = 1'b1;
    clks(10);
    chk("x81_wr_cnt", wr_cnt, 4);
    chk("x81_wdata", wr_data, 8'h81);
    chk("x81_cyc", wr_cyc, n0 + 157);

    // asynchronous reset in the middle of a character
    rx_line = 1'b0;
    clks(80);
    chk("rst_mid_busy_pre", busy, 1);
    #2;
    rst_i = 1'b1;
    #1;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_wdata", wdata, 0);
    chk("rst_mid_wr", wr, 0);
    chk("rst_mid_fe", frame_err, 0);
    chk("rst_mid_ov", overrun, 0);
    rx_line = 1'b1;
    clks(3);
    rst_i = 1'b0;
    clks(10);
    chk("rst_rel_busy", busy, 0);
    send(8'hC3, 1'b1, 0, n0);
    rx_line = 1'b1;
    clks(10);
    chk("post_rst_wr_cnt", wr_cnt, 5);
    chk("post_rst_wdata", wr_data, 8'hC3);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
